prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter_pkg.sv | 20 ++
 rtl/prog_counter_next.sv | 43 ++++
 rtl/prog_counter.sv | 110 +++++++++++
 tb/tb_prog_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable up/down counter.
// Optional snapshot register is enabled by defining PROG_COUNTER_SNAPSHOT_EN.
package prog_counter_pkg;

    localparam int unsigned CNT_WIDTH_MIN = 2;
    localparam int unsigned CNT_WIDTH_MAX = 32;

    // Step direction as seen on up_dn
    typedef enum logic {
        CNT_DN = 1'b0,
        CNT_UP = 1'b1
    } cnt_dir_e;

    // Boundary behaviour as seen on sat_mode
    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

endpackage : prog_counter_pkg

// File: rtl/prog_counter_next.sv
// Combinational next-count and boundary-event logic for prog_counter.
module prog_counter_next
    import prog_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] next_count_c,
    output logic             boundary_c
);

    // One enabled step: compute the following count and flag range-edge crossings
    always_comb begin
        next_count_c = count;
        boundary_c   = 1'b0;
        if (modulus == '0) begin
            // Degenerate range: every step hits the edge and the count pins to 0
            next_count_c = '0;
            boundary_c   = 1'b1;
        end else if (up_dn == CNT_UP) begin
            if (count >= modulus) begin
                boundary_c   = 1'b1;
                next_count_c = (sat_mode == CNT_SAT) ? modulus : '0;
            end else begin
                next_count_c = count + WIDTH'(1);
            end
        end else begin
            if (count == '0) begin
                boundary_c   = 1'b1;
                next_count_c = (sat_mode == CNT_SAT) ? '0 : modulus;
            end else if (count > modulus) begin
                // Modulus was lowered under us: snap back into range
                next_count_c = modulus;
            end else begin
                next_count_c = count - WIDTH'(1);
            end
        end
    end

endmodule : prog_counter_next

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap/saturate modes, terminal-count pulse,
// sticky overflow flag and optional snapshot register (PROG_COUNTER_SNAPSHOT_EN).
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] modulus,
    input  logic             clr_ovf,
    input  logic             snap,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic [WIDTH-1:0] snap_val
);

    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_count_c;
    logic             step_boundary_c;
    logic             boundary_evt_c;

    prog_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count        (count_q),
        .up_dn        (up_dn),
        .sat_mode     (sat_mode),
        .modulus      (modulus),
        .next_count_c (step_count_c),
        .boundary_c   (step_boundary_c)
    );

    // Priority load > enable > hold; boundary events drive tc and ovf
    always_comb begin
        count_d        = count_q;
        tc_d           = 1'b0;
        ovf_d          = ovf_q;
        boundary_evt_c = 1'b0;
        if (load) begin
            count_d = (load_val > modulus) ? modulus : load_val;
        end else if (enable) begin
            count_d        = step_count_c;
            boundary_evt_c = step_boundary_c;
        end
        tc_d = boundary_evt_c;
        if (boundary_evt_c) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Counter state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_CNT;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;

`ifdef PROG_COUNTER_SNAPSHOT_EN
    logic [WIDTH-1:0] snap_val_q, snap_val_d;

    // Capture the pre-step count on a snap strobe
    always_comb begin
        snap_val_d = snap_val_q;
        if (snap) begin
            snap_val_d = count_q;
        end
    end

    // Snapshot register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_val_q <= '0;
        end else begin
            snap_val_q <= snap_val_d;
        end
    end

    assign snap_val = snap_val_q;
`else
    // Snapshot disabled: port kept for a stable interface, input ignored
    logic unused_snap;
    assign unused_snap = snap;
    assign snap_val    = '0;
`endif

endmodule : prog_counter

// File: tb/tb_prog_counter.sv
// Directed scoreboard bench for prog_counter (WIDTH=4, RST_VAL=0).
module tb_prog_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             up_dn;
    logic             sat_mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic             clr_ovf;
    logic             snap;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic [WIDTH-1:0] snap_val;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic [WIDTH-1:0] snap_exp;

    prog_counter #(
        .WIDTH   (WIDTH),
        .RST_VAL (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .load     (load),
        .load_val (load_val),
        .modulus  (modulus),
        .clr_ovf  (clr_ovf),
        .snap     (snap),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf),
        .snap_val (snap_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Wait one clock, then pop the oldest expectation and compare outputs
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty: observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".count"}, 32'(count), 32'(e.count));
            chk({e.tag, ".tc"},    32'(tc),    32'(e.tc));
            chk({e.tag, ".ovf"},   32'(ovf),   32'(e.ovf));
        end
    endtask

    // Drive one cycle of stimulus, record its expected result, then check it
    task automatic step(input string tag, input bit ld, input bit en, input bit ud,
                        input bit sm, input int lv, input int md, input bit co,
                        input int ec, input bit et, input bit eo);
        exp_t e;
        load     = ld;
        enable   = en;
        up_dn    = ud;
        sat_mode = sm;
        load_val = WIDTH'(lv);
        modulus  = WIDTH'(md);
        clr_ovf  = co;
        e.tag    = tag;
        e.count  = WIDTH'(ec);
        e.tc     = et;
        e.ovf    = eo;
        sb.push_back(e);
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b0;
        load_val = '0; modulus = '0; clr_ovf = 1'b0; snap = 1'b0;

        #2;
        chk("reset.count", 32'(count), 0);
        chk("reset.tc", 32'(tc), 0);
        chk("reset.ovf", 32'(ovf), 0);
        chk("reset.snap_val", 32'(snap_val), 0);
        #6 rst_n = 1'b1;

        // Up-wrap over modulus 9
        for (int i = 1; i <= 9; i++) step("up_wrap", 0, 1, 1, 0, 0, 9, 0, i, 0, 0);
        step("up_wrap_edge", 0, 1, 1, 0, 0, 9, 0, 0, 1, 1);
        step("up_wrap_idle", 0, 0, 1, 0, 0, 9, 0, 0, 0, 1);

        // ovf: set wins over clear, then clear alone
        step("ovf_load9", 1, 0, 1, 0, 9, 9, 0, 9, 0, 1);
        step("ovf_set_wins", 0, 1, 1, 0, 0, 9, 1, 0, 1, 1);
        step("ovf_clear", 0, 0, 1, 0, 0, 9, 1, 0, 0, 0);

        // Load beats enable and is clamped to modulus
        step("load_clamp", 1, 1, 1, 0, 12, 9, 0, 9, 0, 0);

        // Runtime modulus change
        step("mod_load8", 1, 0, 1, 0, 8, 9, 0, 8, 0, 0);
        step("mod_dn_clamp", 0, 1, 0, 0, 0, 5, 0, 5, 0, 0);
        step("mod_up_edge", 0, 1, 1, 0, 0, 5, 0, 0, 1, 1);
        step("mod_clr", 0, 0, 1, 0, 0, 5, 1, 0, 0, 0);

        // Down-saturate with back-to-back tc
        step("dsat_load2", 1, 0, 0, 1, 2, 5, 0, 2, 0, 0);
        step("dsat_1", 0, 1, 0, 1, 0, 5, 0, 1, 0, 0);
        step("dsat_0", 0, 1, 0, 1, 0, 5, 0, 0, 0, 0);
        step("dsat_edge_a", 0, 1, 0, 1, 0, 5, 0, 0, 1, 1);
        step("dsat_edge_b", 0, 1, 0, 1, 0, 5, 0, 0, 1, 1);
        step("dsat_idle", 0, 0, 0, 1, 0, 5, 1, 0, 0, 0);

        // Up-saturate holds at modulus
        step("usat_load5", 1, 0, 1, 1, 5, 5, 0, 5, 0, 0);
        step("usat_edge_a", 0, 1, 1, 1, 0, 5, 0, 5, 1, 1);
        step("usat_edge_b", 0, 1, 1, 1, 0, 5, 0, 5, 1, 1);

        // Modulus 0: every step is a boundary event
        step("mod0_step", 0, 1, 1, 0, 0, 0, 1, 0, 1, 1);

        // Full range wraps at 15
        step("full_load15", 1, 0, 1, 0, 15, 15, 0, 15, 0, 1);
        step("full_wrap", 0, 1, 1, 0, 0, 15, 0, 0, 1, 1);
        step("full_after", 0, 1, 1, 0, 0, 15, 0, 1, 0, 1);

        // Down-wrap from 0 to modulus
        step("dwrap_load0", 1, 0, 0, 0, 0, 15, 1, 0, 0, 0);
        step("dwrap_edge", 0, 1, 0, 0, 0, 15, 0, 15, 1, 1);

        // Snapshot captures the pre-step count
        step("snap_load3", 1, 0, 1, 0, 3, 9, 0, 3, 0, 1);
        snap = 1'b1;
        step("snap_step", 0, 1, 1, 0, 0, 9, 0, 4, 0, 1);
        snap = 1'b0;
`ifdef PROG_COUNTER_SNAPSHOT_EN
        snap_exp = 4'd3;
`else
        snap_exp = 4'd0;
`endif
        chk("snap_capture", 32'(snap_val), 32'(snap_exp));
        step("snap_hold", 0, 1, 1, 0, 0, 9, 0, 5, 0, 1);
        chk("snap_hold_val", 32'(snap_val), 32'(snap_exp));

        // Async reset mid-count at 6, no clock edge needed
        step("rst_count6", 0, 1, 1, 0, 0, 9, 0, 6, 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst.count", 32'(count), 0);
        chk("async_rst.tc", 32'(tc), 0);
        chk("async_rst.ovf", 32'(ovf), 0);
        chk("async_rst.snap_val", 32'(snap_val), 0);
        #1 rst_n = 1'b1;
        step("rst_first_step", 0, 1, 1, 0, 0, 9, 0, 1, 0, 0);

        // Reset while tc is high drops the pulse
        step("tcrst_load9", 1, 0, 1, 0, 9, 9, 0, 9, 0, 0);
        step("tcrst_edge", 0, 1, 1, 0, 0, 9, 0, 0, 1, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("tcrst.tc", 32'(tc), 0);
        chk("tcrst.ovf", 32'(ovf), 0);
        #1 rst_n = 1'b1;
        step("tcrst_after", 0, 1, 1, 0, 0, 9, 0, 1, 0, 0);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prog_counter
